// File: rtl/decmuxadd_pkg.sv
// ----------------------------------------------------------------------------
// decmuxadd_pkg : shared sizes, FSM state type and encodings for decmuxadd_arb
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package decmuxadd_pkg;

  localparam int c_n_req_def = 4;
  localparam int c_w_def     = 4;

  localparam logic [1:0] c_st_idle  = 2'b00;
  localparam logic [1:0] c_st_grant = 2'b01;
  localparam logic [1:0] c_st_add   = 2'b10;
  localparam logic [1:0] c_st_resp  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = c_st_idle,
    S_GRANT = c_st_grant,
    S_ADD   = c_st_add,
    S_RESP  = c_st_resp
  } state_e;

  // Width of a binary requester index; never zero even for a single requester.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/decmuxadd_rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick : combinational round-robin picker, search starts at rr_ptr_i
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rr_pick
  import decmuxadd_pkg::*;
#(
  parameter int N_REQ = c_n_req_def,
  parameter int IDW   = idx_w(c_n_req_def)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDW-1:0]   rr_ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IDW-1:0]   idx_o
);

  logic [IDW-1:0] w_cand;
  logic           w_found;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    w_found = 1'b0;
    w_cand  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_cand = IDW'((int'(rr_ptr_i) + k) % N_REQ);
      if (!w_found && req_i[w_cand]) begin
        w_found       = 1'b1;
        gnt_o[w_cand] = 1'b1;
        idx_o         = w_cand;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/decmuxadd_arb.sv
// ----------------------------------------------------------------------------
// decmuxadd_arb : round-robin arbiter feeding a shared registered adder
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module decmuxadd_arb
  import decmuxadd_pkg::*;
#(
  parameter int N_REQ = c_n_req_def,
  parameter int W     = c_w_def
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] opx,
  input  logic [N_REQ*W-1:0] opy,
  input  logic [N_REQ-1:0]   cin,
  output logic [N_REQ-1:0]   gnt,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [W-1:0]       res_sum,
  output logic               res_co,
  output logic [1:0]         res_id,
  output logic               busy
);

  localparam int IDW = idx_w(N_REQ);

  state_e           state_q;
  logic [IDW-1:0]   rr_ptr_q;
  logic [IDW-1:0]   rr_ptr_d;
  logic [W-1:0]     x_q;
  logic [W-1:0]     y_q;
  logic             ci_q;
  logic [IDW-1:0]   id_q;
  logic [N_REQ-1:0] gnt_q;
  logic             res_valid_q;
  logic [W-1:0]     res_sum_q;
  logic             res_co_q;
  logic [1:0]       res_id_q;
  logic             busy_q;
  logic [W:0]       sum_d;

  logic [N_REQ-1:0] w_pick_gnt;
  logic [IDW-1:0]   w_pick_idx;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_rr_pick (
    .req_i    (req),
    .rr_ptr_i (rr_ptr_q),
    .gnt_o    (w_pick_gnt),
    .idx_o    (w_pick_idx)
  );

  assign rr_ptr_d = IDW'((int'(w_pick_idx) + 1) % N_REQ);
  assign sum_d    = {1'b0, x_q} + {1'b0, y_q} + {{W{1'b0}}, ci_q};

  // Operands are captured only at the arbitration edge; later req/operand
  // activity cannot disturb a transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      x_q         <= '0;
      y_q         <= '0;
      ci_q        <= 1'b0;
      id_q        <= '0;
      gnt_q       <= '0;
      res_valid_q <= 1'b0;
      res_sum_q   <= '0;
      res_co_q    <= 1'b0;
      res_id_q    <= '0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (|req) begin
            x_q      <= opx[w_pick_idx*W +: W];
            y_q      <= opy[w_pick_idx*W +: W];
            ci_q     <= cin[w_pick_idx];
            id_q     <= w_pick_idx;
            rr_ptr_q <= rr_ptr_d;
            gnt_q    <= w_pick_gnt;
            busy_q   <= 1'b1;
            state_q  <= S_GRANT;
          end
        end
        S_GRANT: begin
          gnt_q   <= '0;
          state_q <= S_ADD;
        end
        S_ADD: begin
          {res_co_q, res_sum_q} <= sum_d;
          res_id_q    <= 2'(id_q);
          res_valid_q <= 1'b1;
          state_q     <= S_RESP;
        end
        S_RESP: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign res_valid = res_valid_q;
  assign res_sum   = res_sum_q;
  assign res_co    = res_co_q;
  assign res_id    = res_id_q;
  assign busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_decmuxadd_arb.sv
// ----------------------------------------------------------------------------
// tb_decmuxadd_arb : scoreboard bench for decmuxadd_arb
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_decmuxadd_arb;

  localparam int N = 4;
  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] opx;
  logic [N*W-1:0] opy;
  logic [N-1:0]   cin;
  logic [N-1:0]   gnt;
  logic           res_valid;
  logic           res_ready;
  logic [W-1:0]   res_sum;
  logic           res_co;
  logic [1:0]     res_id;
  logic           busy;

  int checks = 0;
  int errors = 0;

  // Scoreboard entry: {id[1:0], co, sum[3:0]}
  logic [6:0] sb[$];
  logic [6:0] mon_exp;

  always #5 clk = ~clk;

  decmuxadd_arb #(.N_REQ(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .opx       (opx),
    .opy       (opy),
    .cin       (cin),
    .gnt       (gnt),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_co    (res_co),
    .res_id    (res_id),
    .busy      (busy)
  );

  function automatic logic [6:0] model(input int id, input logic [3:0] x, input logic [3:0] y,
                                       input logic ci);
    logic [4:0] s;
    s = {1'b0, x} + {1'b0, y} + {4'b0000, ci};
    return {2'(id), s};
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_lane(input int i, input logic [3:0] x, input logic [3:0] y, input logic ci);
    opx[i*W +: W] = x;
    opy[i*W +: W] = y;
    cin[i]        = ci;
  endtask

  // Result monitor: every accepted response is matched against the queue head.
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL resp_unexpected: got id=%0d co=%0b sum=%0d, required no response",
                 res_id, res_co, res_sum);
      end else begin
        mon_exp = sb.pop_front();
        if ({res_id, res_co, res_sum} !== mon_exp) begin
          errors++;
          $display("FAIL resp_data: got id=%0d co=%0b sum=%0d, required id=%0d co=%0b sum=%0d",
                   res_id, res_co, res_sum, mon_exp[6:5], mon_exp[4], mon_exp[3:0]);
        end
      end
    end
  end

  task automatic test_reset();
    step();
    step();
    checks++;
    if ({gnt, res_valid, res_sum, res_co, res_id, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got gnt=%b v=%b sum=%0d co=%b id=%0d busy=%b, required all 0",
               gnt, res_valid, res_sum, res_co, res_id, busy);
    end
    rst = 1'b0;
    step();
    checks++;
    if ({gnt, res_valid, busy} !== '0) begin
      errors++;
      $display("FAIL reset_idle: got gnt=%b v=%b busy=%b, required 0", gnt, res_valid, busy);
    end
  endtask

  task automatic test_single();
    set_lane(0, 4'd3, 4'd4, 1'b1);
    req = 4'b0001;
    sb.push_back({2'd0, 1'b0, 4'd8});
    step();
    checks++;
    if (gnt !== 4'b0001 || busy !== 1'b1 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_grant: got gnt=%b busy=%b v=%b, required 0001 1 0", gnt, busy, res_valid);
    end
    req = '0;
    step();
    checks++;
    if (gnt !== 4'b0000 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_add: got gnt=%b v=%b, required 0000 0", gnt, res_valid);
    end
    step();
    checks++;
    if (res_valid !== 1'b1) begin
      errors++;
      $display("FAIL single_latency: got v=%b, required 1", res_valid);
    end
    step();
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: got v=%b busy=%b, required 0 0", res_valid, busy);
    end
  endtask

  task automatic test_overflow();
    logic [3:0] xs [2] = '{4'd15, 4'd8};
    logic [3:0] ys [2] = '{4'd15, 4'd8};
    logic       cs [2] = '{1'b1, 1'b0};
    logic [6:0] ex [2] = '{{2'd1, 1'b1, 4'd15}, {2'd2, 1'b1, 4'd0}};
    for (int t = 0; t < 2; t++) begin
      set_lane(t + 1, xs[t], ys[t], cs[t]);
      req = 4'(1 << (t + 1));
      sb.push_back(ex[t]);
      step();
      checks++;
      if (gnt !== 4'(1 << (t + 1))) begin
        errors++;
        $display("FAIL ovf_grant%0d: got gnt=%b, required %b", t, gnt, 4'(1 << (t + 1)));
      end
      req = '0;
      step();
      step();
      step();
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL ovf_idle%0d: got busy=%b, required 0", t, busy);
      end
    end
  endtask

  task automatic test_fairness();
    int order [5] = '{0, 1, 2, 3, 0};
    logic [N-1:0] exp_g;
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < N; i++) set_lane(i, 4'(i * 5 + 2), 4'(i * 3 + 7), i[0]);
    for (int k = 0; k < 5; k++)
      sb.push_back(model(order[k], 4'(order[k] * 5 + 2), 4'(order[k] * 3 + 7), order[k] % 2 == 1));
    req = 4'b1111;
    for (int c = 1; c <= 20; c++) begin
      step();
      exp_g = ((c - 1) % 4 == 0) ? 4'(1 << order[(c - 1) / 4]) : 4'b0000;
      checks++;
      if (gnt !== exp_g || res_valid !== (c % 4 == 3) || busy !== (c % 4 != 0)) begin
        errors++;
        $display("FAIL fair_cycle%0d: got gnt=%b v=%b busy=%b, required gnt=%b v=%b busy=%b",
                 c, gnt, res_valid, busy, exp_g, c % 4 == 3, c % 4 != 0);
      end
      if (c == 19) req = '0;
    end
  endtask

  task automatic test_backpressure();
    set_lane(1, 4'd9, 4'd5, 1'b1);
    req = 4'b0010;
    res_ready = 1'b0;
    sb.push_back({2'd1, 1'b0, 4'd15});
    step();
    checks++;
    if (gnt !== 4'b0010) begin
      errors++;
      $display("FAIL bp_grant: got gnt=%b, required 0010", gnt);
    end
    req = '0;
    step();
    for (int k = 0; k < 6; k++) begin
      step();
      checks++;
      if (res_valid !== 1'b1 || {res_id, res_co, res_sum} !== {2'd1, 1'b0, 4'd15} ||
          busy !== 1'b1 || gnt !== 4'b0000) begin
        errors++;
        $display("FAIL bp_hold%0d: got v=%b id=%0d co=%b sum=%0d busy=%b gnt=%b, required 1 1 0 15 1 0000",
                 k, res_valid, res_id, res_co, res_sum, busy, gnt);
      end
      if (k == 5) res_ready = 1'b1;
    end
    step();
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: got v=%b busy=%b, required 0 0", res_valid, busy);
    end
  endtask

  task automatic test_late_req();
    set_lane(0, 4'd1, 4'd2, 1'b0);
    req = 4'b0001;
    sb.push_back({2'd0, 1'b0, 4'd3});
    step();
    req = '0;
    step();
    set_lane(2, 4'd6, 4'd7, 1'b1);
    req = 4'b0100;
    sb.push_back({2'd2, 1'b0, 4'd14});
    step();
    checks++;
    if (gnt !== 4'b0000 || res_valid !== 1'b1) begin
      errors++;
      $display("FAIL late_resp: got gnt=%b v=%b, required 0000 1", gnt, res_valid);
    end
    step();
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL late_idle: got gnt=%b busy=%b, required 0000 0", gnt, busy);
    end
    step();
    checks++;
    if (gnt !== 4'b0100) begin
      errors++;
      $display("FAIL late_grant: got gnt=%b, required 0100", gnt);
    end
    req = '0;
    step();
    step();
    step();
  endtask

  task automatic test_reset_in_add();
    set_lane(3, 4'd2, 4'd2, 1'b0);
    req = 4'b1000;
    sb.push_back({2'd3, 1'b0, 4'd4});
    step();
    req = '0;
    step();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL rstadd_busy: got busy=%b, required 1", busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({gnt, res_valid, res_sum, res_co, res_id, busy} !== '0) begin
      errors++;
      $display("FAIL rstadd_async: got gnt=%b v=%b sum=%0d co=%b id=%0d busy=%b, required all 0",
               gnt, res_valid, res_sum, res_co, res_id, busy);
    end
    sb.delete();
    step();
    rst = 1'b0;
    set_lane(1, 4'd4, 4'd5, 1'b0);
    set_lane(3, 4'd1, 4'd1, 1'b1);
    req = 4'b1010;
    sb.push_back({2'd1, 1'b0, 4'd9});
    step();
    checks++;
    if (gnt !== 4'b0010) begin
      errors++;
      $display("FAIL rstadd_first_grant: got gnt=%b, required 0010", gnt);
    end
    req = '0;
    step();
    step();
    step();
    checks++;
    if (busy !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL rstadd_drain: got busy=%b pending=%0d, required 0 0", busy, sb.size());
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    req       = '0;
    opx       = '0;
    opy       = '0;
    cin       = '0;
    res_ready = 1'b1;
    test_reset();
    test_single();
    test_overflow();
    test_fairness();
    test_backpressure();
    test_late_req();
    test_reset_in_add();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/decmuxadd_arb.md
DECMUXADD_ARB -- requirements
Module: decmuxadd_arb

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, giving the number of requesters (fixed at 4 for this release).
REQ-002 The block SHALL have parameter W, default 4, giving the operand and sum width in bits.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset, named clk and rst.
REQ-004 Port clk, input, 1 bit: sole clock; all state updates on the rising edge.
REQ-005 Port rst, input, 1 bit: asynchronous active-high reset.
REQ-006 Port req, input, N_REQ bits: per-requester request, level.
REQ-007 Port opx, input, N_REQ*W bits: packed X operands; requester i occupies bits [i*W +: W].
REQ-008 Port opy, input, N_REQ*W bits: packed Y operands, same packing as opx.
REQ-009 Port cin, input, N_REQ bits: per-requester carry-in.
REQ-010 Port gnt, output, N_REQ bits: one-hot grant pulse.
REQ-011 Port res_valid, output, 1 bit: result available.
REQ-012 Port res_ready, input, 1 bit: consumer accepts the result.
REQ-013 Port res_sum, output, W bits: sum result.
REQ-014 Port res_co, output, 1 bit: carry-out result.
REQ-015 Port res_id, output, 2 bits: index of the serviced requester.
REQ-016 Port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-017 The FSM SHALL have exactly four states: IDLE, GRANT, ADD, RESP.
REQ-018 In IDLE with req nonzero, the block SHALL perform these actions at the edge, then go to GRANT:
- pick the winner round-robin, starting at pointer rr_ptr;
- latch the winner's opx, opy, cin and index;
- set rr_ptr to (winner+1) mod N_REQ.
REQ-019 In IDLE with req zero, the block SHALL stay in IDLE and leave rr_ptr unchanged.
REQ-020 In GRANT, gnt[winner] SHALL be 1 for exactly one cycle and all other gnt bits 0; the next state is ADD.
REQ-021 In ADD, the block SHALL register {res_co,res_sum} = X + Y + Ci, computed W+1 bits wide; the next state is RESP.
REQ-022 Sum wrap-around SHALL be modular: res_sum = (X+Y+Ci) mod 2^W, and res_co = bit W of the sum.
REQ-023 In RESP, res_valid SHALL be 1; res_sum, res_co and res_id SHALL be held stable until res_valid && res_ready, after which the next state is IDLE.
REQ-024 res_ready SHALL be ignored outside RESP.
REQ-025 req changes outside IDLE SHALL be ignored; operands SHALL be sampled only at the IDLE arbitration edge.
REQ-026 Requesters SHALL hold req and operands until they see gnt; a req still high after gnt is treated as a new request.
REQ-027 Latency SHALL be: req sampled at edge t -> gnt high in cycle t+1 -> res_valid high in cycle t+3.
REQ-028 Throughput with res_ready tied high SHALL be one transaction per 4 cycles.
REQ-029 No requester with req held continuously SHALL wait more than N_REQ-1 other transactions.

Reset
REQ-030 While rst is high, the block SHALL hold:
- state = IDLE, rr_ptr = 0;
- gnt = 0, res_valid = 0, res_sum = 0, res_co = 0, res_id = 0, busy = 0.
REQ-031 Reset asserted mid-transaction SHALL abort the transaction with no response; the first arbitration after reset release starts from requester 0.

Structure
REQ-032 Package decmuxadd_pkg SHALL hold:
- the N_REQ and W defaults;
- the FSM state enum;
- the state encoding constants.
REQ-033 The round-robin picker SHALL be a sub-module rr_pick: inputs req and rr_ptr, outputs a one-hot grant and a binary index, purely combinational.
REQ-034 All outputs SHALL be driven from registers; there is no combinational path from req or res_ready to any output.

Verification
REQ-035 Scenario 1 -- single request: req=0001, X0=3, Y0=4, Ci0=1 -> gnt=0001 for one cycle; res_sum=8, res_co=0, res_id=0; res_valid rises 3 cycles after the sampling edge.
REQ-036 Scenario 2 -- overflow: X=15, Y=15, Ci=1 -> res_sum=15, res_co=1; X=8, Y=8, Ci=0 -> res_sum=0, res_co=1.
REQ-037 Scenario 3 -- fairness: req=1111 held, res_ready=1 -> grant order 0,1,2,3,0 with one transaction every 4 cycles.
REQ-038 Scenario 4 -- backpressure: res_ready=0 for 5 cycles in RESP -> res_valid and data stable, busy=1, no gnt; then res_ready=1 for 1 cycle -> IDLE next cycle.
REQ-039 Scenario 5 -- late request: req=0100 raised while in ADD -> ignored until IDLE; then serviced with res_id=2.
REQ-040 Scenario 6 -- reset in ADD: rst pulsed -> all outputs 0 immediately; after release, req=1010 -> gnt=0010 first.
